// File: rtl/satround_rr_arbiter_if.sv
// Handshake bundle between producers, the shared requantizer and the downstream consumer.
// slave is the arbiter's view; master is the surrounding environment's view.
interface satround_rr_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned NB_XI = 20,
  parameter int unsigned NB_XO = 8
) ();
  localparam int unsigned NbId = $clog2(N_REQ);

  logic [N_REQ-1:0]       i_valid;
  logic [N_REQ*NB_XI-1:0] i_data;
  logic [N_REQ-1:0]       o_ready;
  logic                   o_valid;
  logic                   i_ready;
  logic [NB_XO-1:0]       o_data;
  logic [NbId-1:0]        o_id;
  logic                   o_sat;

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_data, o_id, o_sat
  );

  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_data, o_id, o_sat
  );
endinterface

// File: rtl/satround_rr_arbiter.sv
// Round-robin arbiter sharing one round-half-up / saturating requantizer between N_REQ
// producers, with a single registered output stage and a sticky saturation-event counter.
module satround_rr_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned NB_XI  = 20,
  parameter int unsigned NBF_XI = 12,
  parameter int unsigned NB_XO  = 8,
  parameter int unsigned NBF_XO = 6,
  parameter int unsigned NB_CNT = 16
) (
  input  logic                 i_clock,
  input  logic                 i_rst_n,
  satround_rr_arbiter_if.slave bus,
  input  logic                 i_clr_count,
  output logic [NB_CNT-1:0]    o_sat_count
);
  localparam int unsigned NbId  = $clog2(N_REQ);
  localparam int unsigned Shift = NBF_XI - NBF_XO;
  localparam int unsigned NbRnd = NB_XI + 1 - Shift;

  logic [NbId-1:0]   ptr_q, ptr_d;
  logic [NbId-1:0]   cand, win_idx;
  logic              win_found, slot_free, xfer;
  logic              valid_q, valid_d;
  logic [NB_XO-1:0]  data_q, data_d, rq_data;
  logic [NbId-1:0]   id_q, id_d;
  logic              sat_q, sat_d, rq_sat;
  logic [NB_CNT-1:0] cnt_q, cnt_d;
  logic [NB_XI-1:0]  sample;
  logic [NB_XI:0]    rnd_sum;
  logic [NbRnd-1:0]  rnd_val;

  // First valid requester at or after the priority pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = NbId'((32'(ptr_q) + i) % N_REQ);
      if (!win_found && bus.i_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    sample = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (win_idx == NbId'(k)) sample = bus.i_data[k*NB_XI +: NB_XI];
    end
  end

  assign slot_free   = !valid_q || bus.i_ready;
  assign xfer        = win_found && slot_free;
  assign bus.o_ready = xfer ? (N_REQ'(1) << win_idx) : '0;

  // Round half up: add half an output LSB in one extra guard bit, then drop the fraction.
  if (Shift > 0) begin : g_rnd
    localparam logic [NB_XI:0] Half = (NB_XI + 1)'(1) << (Shift - 1);
    assign rnd_sum = {sample[NB_XI-1], sample} + Half;
  end else begin : g_nornd
    assign rnd_sum = {sample[NB_XI-1], sample};
  end
  assign rnd_val = NbRnd'(rnd_sum >> Shift);

  if (NbRnd > NB_XO) begin : g_sat
    logic [NbRnd-NB_XO:0] hi;
    assign hi      = rnd_val[NbRnd-1:NB_XO-1];
    assign rq_sat  = !((&hi) || !(|hi));
    assign rq_data = rq_sat ? {rnd_val[NbRnd-1], {(NB_XO-1){~rnd_val[NbRnd-1]}}}
                            : rnd_val[NB_XO-1:0];
  end else begin : g_nosat
    assign rq_sat  = 1'b0;
    assign rq_data = NB_XO'($signed(rnd_val));
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    id_d    = id_q;
    sat_d   = sat_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (xfer) begin
      valid_d = 1'b1;
      data_d  = rq_data;
      id_d    = win_idx;
      sat_d   = rq_sat;
      ptr_d   = (win_idx == NbId'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    end else if (bus.i_ready) begin
      valid_d = 1'b0;
    end
    if (i_clr_count) begin
      cnt_d = '0;
    end else if (xfer && rq_sat && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      id_q    <= '0;
      sat_q   <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      id_q    <= id_d;
      sat_q   <= sat_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.o_valid = valid_q;
  assign bus.o_data  = data_q;
  assign bus.o_id    = id_q;
  assign bus.o_sat   = sat_q;
  assign o_sat_count = cnt_q;
endmodule
